// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared scoreboard entry type, constants and decoder opcodes for
//            the hazard/stall controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Upper bound on REG_AW; wider register indices do not fit an entry.
    localparam int SB_DEST_W = 5;

    localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

    localparam logic [5:0] OP_LD = 6'd36;
    localparam logic [5:0] OP_ST = 6'd37;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 wb_en;
        logic                 mem_r;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: REG_ZERO, wb_en: 1'b0, mem_r: 1'b0};

    function automatic logic is_writer(input sb_entry_t e);
        return e.valid & e.wb_en & (e.dest != REG_ZERO);
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Three-slot EXE/MEM/WB shift register of in-flight writers with
//            whole-pipe hold and NOP insertion into the EXE slot.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      i_hold,
    input  wire logic      i_bubble,
    input  wire sb_entry_t i_entry,
    output sb_entry_t      o_exe,
    output sb_entry_t      o_mem,
    output sb_entry_t      o_wb
);

    sb_entry_t r_exe;
    sb_entry_t r_mem;
    sb_entry_t r_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe <= SB_EMPTY;
            r_mem <= SB_EMPTY;
            r_wb  <= SB_EMPTY;
        end else if (!i_hold) begin
            r_wb  <= r_mem;
            r_mem <= r_exe;
            r_exe <= i_bubble ? SB_EMPTY : i_entry;
        end
    end

    assign o_exe = r_exe;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Brief    : RAW hazard detection beside ID; drives freeze/bubble/flush and
//            saturating stall/flush counters. Macro HAZARD_FORWARDING_EN
//            limits hazards to EXE-slot load-use.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int WB_BYPASS = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              id_valid,
    input  wire logic [REG_AW-1:0] id_src1,
    input  wire logic [REG_AW-1:0] id_src2,
    input  wire logic              id_use_src2,
    input  wire logic [REG_AW-1:0] id_dest,
    input  wire logic              id_wb_en,
    input  wire logic              id_mem_r_en,
    input  wire logic              id_branch_taken,
    input  wire logic              mem_busy,
    output logic                   freeze,
    output logic                   bubble,
    output logic                   flush,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    sb_entry_t w_entry;
    sb_entry_t w_exe;
    sb_entry_t w_mem;
    sb_entry_t w_wb;
    logic      w_hit_exe;
    logic      w_hit_mem;
    logic      w_hit_wb;
    logic      w_hazard;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic src_hit(input sb_entry_t e,
                                     input logic [REG_AW-1:0] s1,
                                     input logic [REG_AW-1:0] s2,
                                     input logic use2);
        return is_writer(e) & ((e.dest == SB_DEST_W'(s1)) |
                               (use2 & (e.dest == SB_DEST_W'(s2))));
    endfunction

    assign w_entry = '{valid: id_valid, dest: SB_DEST_W'(id_dest),
                       wb_en: id_wb_en, mem_r: id_mem_r_en};

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (mem_busy),
        .i_bubble (bubble),
        .i_entry  (w_entry),
        .o_exe    (w_exe),
        .o_mem    (w_mem),
        .o_wb     (w_wb)
    );

    assign w_hit_exe = src_hit(w_exe, id_src1, id_src2, id_use_src2);
    assign w_hit_mem = src_hit(w_mem, id_src1, id_src2, id_use_src2);

    generate
        if (WB_BYPASS != 0) begin : g_wb_bypass
            // Write-before-read register file already supplies the WB value.
            assign w_hit_wb = 1'b0;
        end else begin : g_wb_check
            assign w_hit_wb = src_hit(w_wb, id_src1, id_src2, id_use_src2);
        end
    endgenerate

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = id_valid & w_hit_exe & w_exe.mem_r;
`else
    assign w_hazard = id_valid & (w_hit_exe | w_hit_mem | w_hit_wb);
`endif

    assign freeze = w_hazard | mem_busy;
    assign bubble = w_hazard & ~mem_busy;
    assign flush  = id_branch_taken & id_valid & ~w_hazard & ~mem_busy;

    // Both counters saturate at all-ones; mem_busy is already folded into bubble/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bubble && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : hazard_stall_controller
`default_nettype wire
